abc_seq_ctrl: RTL and testbench

- Sequencer for the registered 3-input decoder datapath (inputs a/b/c, registered outputs y/z, 1-cycle latency).
- On `start`, it latches a list of NUM_STEPS 3-bit codes. It drives the codes to the decoder one at a time and captures each registered y/z response.
- It checks each response against the golden decode table and reports per-step results and error flags with a busy/done handshake.

---
 rtl/abc_seq_pkg.sv | 41 ++++
 rtl/abc_seq_ctrl_if.sv | 34 +++
 rtl/abc_expect.sv | 18 +
 rtl/abc_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_abc_seq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/abc_seq_pkg.sv
// Shared constants for the abc decoder sequencer: FSM encoding, the three
// codes with a defined z output, and the golden decode table.
package abc_seq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [2:0] CODE_111 = 3'b111;
  localparam logic [2:0] CODE_110 = 3'b110;
  localparam logic [2:0] CODE_100 = 3'b100;

  localparam logic GOLD_Y_111   = 1'b0;
  localparam logic GOLD_Z_111   = 1'b1;
  localparam logic GOLD_Y_110   = 1'b1;
  localparam logic GOLD_Z_110   = 1'b1;
  localparam logic GOLD_Y_100   = 1'b0;
  localparam logic GOLD_Z_100   = 1'b0;
  localparam logic GOLD_Y_OTHER = 1'b0;

  typedef struct packed {
    logic y;
    logic z;
    logic zv;
  } golden_t;

  // Codes outside the table still get a defined z (0) so nothing downstream
  // ever depends on a don't-care value.
  function automatic golden_t golden(input logic [2:0] code);
    golden_t g;
    case (code)
      CODE_111: g = '{y: GOLD_Y_111, z: GOLD_Z_111, zv: 1'b1};
      CODE_110: g = '{y: GOLD_Y_110, z: GOLD_Z_110, zv: 1'b1};
      CODE_100: g = '{y: GOLD_Y_100, z: GOLD_Z_100, zv: 1'b1};
      default:  g = '{y: GOLD_Y_OTHER, z: 1'b0, zv: 1'b0};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/abc_seq_ctrl_if.sv
// Bundle between the sequencer and its environment (requester + decoder).
// Handshake: start is sampled only while the sequencer is idle; busy rises the
// cycle after acceptance and drops when done pulses for exactly one cycle.
interface abc_seq_ctrl_if #(
  parameter int NUM_STEPS = 4
);
  logic                   start;
  logic [3*NUM_STEPS-1:0] code_list;
  logic                   dec_a;
  logic                   dec_b;
  logic                   dec_c;
  logic                   dec_y;
  logic                   dec_z;
  logic                   busy;
  logic                   done;
  logic [NUM_STEPS-1:0]   y_vec;
  logic [NUM_STEPS-1:0]   z_vec;
  logic [NUM_STEPS-1:0]   z_valid;
  logic [NUM_STEPS-1:0]   err_vec;
  logic [1:0]             dbg_state;

  modport slave (
    input  start, code_list, dec_y, dec_z,
    output dec_a, dec_b, dec_c, busy, done,
    output y_vec, z_vec, z_valid, err_vec, dbg_state
  );

  modport master (
    output start, code_list, dec_y, dec_z,
    input  dec_a, dec_b, dec_c, busy, done,
    input  y_vec, z_vec, z_valid, err_vec, dbg_state
  );

endinterface

// File: rtl/abc_expect.sv
// Combinational golden-table lookup: {a,b,c} -> expected y, z and z-valid.
module abc_expect
  import abc_seq_pkg::*;
(
  input  logic [2:0] i_code,
  output logic       o_exp_y,
  output logic       o_exp_z,
  output logic       o_exp_zv
);

  golden_t w_g;

  assign w_g      = golden(i_code);
  assign o_exp_y  = w_g.y;
  assign o_exp_z  = w_g.z;
  assign o_exp_zv = w_g.zv;

endmodule

// File: rtl/abc_seq_ctrl.sv
// Drives a latched list of 3-bit codes into a registered decoder one per two
// cycles, captures each y/z response and flags mismatches against the table.
module abc_seq_ctrl
  import abc_seq_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int CNT_W     = 3
) (
  input  logic          clk,
  input  logic          rst,
  abc_seq_ctrl_if.slave sif
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_step;
  logic [3*NUM_STEPS-1:0] r_codes;
  logic [2:0]             r_dec;
  logic                   r_busy;
  logic                   r_done;
  logic [NUM_STEPS-1:0]   r_y;
  logic [NUM_STEPS-1:0]   r_z;
  logic [NUM_STEPS-1:0]   r_zv;
  logic [NUM_STEPS-1:0]   r_err;

  logic [2:0] w_cur_code;
  logic [2:0] w_next_code;
  logic       w_exp_y;
  logic       w_exp_z;
  logic       w_exp_zv;
  logic       w_y_err;
  logic       w_z_err;
  logic       w_z_cap;

  // Step selection by comparison loop keeps indexing independent of CNT_W.
  always_comb begin
    w_cur_code  = r_codes[2:0];
    w_next_code = r_codes[2:0];
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (int'(r_step) == i)     w_cur_code  = r_codes[3*i +: 3];
      if (int'(r_step) + 1 == i) w_next_code = r_codes[3*i +: 3];
    end
  end

  abc_expect u_expect (
    .i_code   (w_cur_code),
    .o_exp_y  (w_exp_y),
    .o_exp_z  (w_exp_z),
    .o_exp_zv (w_exp_zv)
  );

  // dec_z is only looked at when z is defined for the code, so an unknown z
  // on a don't-care code cannot reach z_vec or err_vec.
  assign w_y_err = (sif.dec_y != w_exp_y);
  assign w_z_err = w_exp_zv ? (sif.dec_z != w_exp_z) : 1'b0;
  assign w_z_cap = w_exp_zv ? sif.dec_z : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_codes <= '0;
      r_dec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_z     <= '0;
      r_zv    <= '0;
      r_err   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sif.start) begin
            r_codes <= sif.code_list;
            r_y     <= '0;
            r_z     <= '0;
            r_zv    <= '0;
            r_err   <= '0;
            r_step  <= '0;
            r_dec   <= sif.code_list[2:0];
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          for (int i = 0; i < NUM_STEPS; i++) begin
            if (int'(r_step) == i) begin
              r_y[i]   <= sif.dec_y;
              r_zv[i]  <= w_exp_zv;
              r_z[i]   <= w_z_cap;
              r_err[i] <= w_y_err | w_z_err;
            end
          end
          if (r_step == LAST_STEP) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_step  <= r_step + CNT_W'(1);
            r_dec   <= w_next_code;
            r_state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sif.dec_a     = r_dec[2];
  assign sif.dec_b     = r_dec[1];
  assign sif.dec_c     = r_dec[0];
  assign sif.busy      = r_busy;
  assign sif.done      = r_done;
  assign sif.y_vec     = r_y;
  assign sif.z_vec     = r_z;
  assign sif.z_valid   = r_zv;
  assign sif.err_vec   = r_err;
  assign sif.dbg_state = r_state;

endmodule

// File: tb/tb_abc_seq_ctrl.sv
// Bench for abc_seq_ctrl: a 4-step and a 1-step instance, each driving a
// behavioural registered decoder with optional fault injection.
module tb_abc_seq_ctrl;

  logic clk;
  logic rst;

  abc_seq_ctrl_if #(.NUM_STEPS(4)) if4 ();
  abc_seq_ctrl_if #(.NUM_STEPS(1)) if1 ();

  abc_seq_ctrl #(.NUM_STEPS(4), .CNT_W(3)) dut4 (.clk(clk), .rst(rst), .sif(if4));
  abc_seq_ctrl #(.NUM_STEPS(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .sif(if1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- decoder models ----------------
  logic       dec4_stuck;
  logic [7:0] dec4_fy;
  logic [7:0] dec4_fz;
  logic [2:0] c4;
  logic [2:0] c1;

  function automatic logic code_has_z(input logic [2:0] c);
    return (c == 3'b111) || (c == 3'b110) || (c == 3'b100);
  endfunction

  always @(posedge clk) begin
    c4 = {if4.dec_a, if4.dec_b, if4.dec_c};
    if4.dec_y <= dec4_stuck ? 1'b1 : ((c4 == 3'b110) ^ dec4_fy[c4]);
    if (code_has_z(c4)) if4.dec_z <= (c4 != 3'b100) ^ dec4_fz[c4];
    else                if4.dec_z <= 1'($urandom);
  end

  always @(posedge clk) begin
    c1 = {if1.dec_a, if1.dec_b, if1.dec_c};
    if1.dec_y <= (c1 == 3'b110);
    if (code_has_z(c1)) if1.dec_z <= (c1 != 3'b100);
    else                if1.dec_z <= 1'($urandom);
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Result of a 4-step run, packed {y_vec, z_vec, z_valid, err_vec}, from the
  // table rules applied to what the faulty decoder will answer per code.
  function automatic logic [15:0] model4(input logic [11:0] codes, input logic stuck,
                                         input logic [7:0] fy, input logic [7:0] fz);
    logic [3:0] y, z, zv, err;
    logic [2:0] c;
    logic gy, gz, v, ry;
    for (int k = 0; k < 4; k++) begin
      c   = codes[3*k +: 3];
      gy  = (c == 3'b110);
      gz  = (c == 3'b111) || (c == 3'b110);
      v   = code_has_z(c);
      ry  = stuck ? 1'b1 : (gy ^ fy[c]);
      y[k]   = ry;
      zv[k]  = v;
      z[k]   = v ? (gz ^ fz[c]) : 1'b0;
      err[k] = (ry != gy) | (v & fz[c]);
    end
    return {y, z, zv, err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run4(input logic [11:0] codes, input logic [15:0] exp,
                      input bit spam, input bit chg, input string nm);
    int done_cnt = 0;
    int done_at  = 0;
    bit dec_ok   = 1;
    bit busy_ok  = 1;
    int idx;
    logic [15:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    if4.code_list = codes;
    if4.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    // k counts edges after the accepting edge; done is expected on edge 2N
    // after it, i.e. the (2N+1)-th edge counting the accepting one.
    for (int k = 0; k <= 12; k++) begin
      idx = (k / 2 > 3) ? 3 : k / 2;
      if ({if4.dec_a, if4.dec_b, if4.dec_c} !== codes[3*idx +: 3]) dec_ok = 0;
      if (if4.busy !== (k < 8)) busy_ok = 0;
      if (if4.done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k + 1;
      end
      if (spam && (k == 3 || k == 8)) if4.start = 1'b1;
      if (spam && (k == 4 || k == 9)) if4.start = 1'b0;
      if (chg && k == 3) if4.code_list = 12'hFFF;
      if (k < 12) @(negedge clk);
    end
    check({nm, " dec_abc"}, 32'(dec_ok), 32'd1);
    check({nm, " busy"}, 32'(busy_ok), 32'd1);
    check({nm, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({nm, " done_at"}, 32'(done_at), 32'd9);
    e = exp_q.pop_front();
    check({nm, " y_vec"},   32'(if4.y_vec),   32'(e[15:12]));
    check({nm, " z_vec"},   32'(if4.z_vec),   32'(e[11:8]));
    check({nm, " z_valid"}, 32'(if4.z_valid), 32'(e[7:4]));
    check({nm, " err_vec"}, 32'(if4.err_vec), 32'(e[3:0]));
  endtask

  task automatic set_decoder(input logic stuck, input logic [7:0] fy, input logic [7:0] fz);
    @(negedge clk);
    dec4_stuck = stuck;
    dec4_fy    = fy;
    dec4_fz    = fz;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [11:0] codes;
    logic        stuck;
    bit          spam;
    bit          chg;
    logic [3:0]  y, z, zv, err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [11:0] rc;
    logic        rs;
    logic [7:0]  rfy, rfz;

    vecs[0] = '{"basic",    12'b000_111_110_100, 1'b0, 0, 0, 4'b0010, 4'b0110, 4'b0111, 4'b0000};
    vecs[1] = '{"y_stuck",  12'b101_100_110_111, 1'b1, 0, 0, 4'b1111, 4'b0011, 4'b0111, 4'b1101};
    vecs[2] = '{"start_ig", 12'b000_111_110_100, 1'b0, 1, 0, 4'b0010, 4'b0110, 4'b0111, 4'b0000};
    vecs[3] = '{"list_chg", 12'b001_010_011_100, 1'b0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[4] = '{"all_111",  12'b111_111_111_111, 1'b0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    vecs[5] = '{"stuck110", 12'b110_110_110_110, 1'b1, 0, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0000};

    rst = 1'b1;
    if4.start = 1'b0; if4.code_list = '0;
    if1.start = 1'b0; if1.code_list = '0;
    dec4_stuck = 1'b0; dec4_fy = '0; dec4_fz = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst state",   32'(if4.dbg_state), 32'd0);
    check("rst busy_done", {30'd0, if4.busy, if4.done}, 32'd0);
    check("rst dec_abc", {29'd0, if4.dec_a, if4.dec_b, if4.dec_c}, 32'd0);
    check("rst vectors", {16'd0, if4.y_vec, if4.z_vec, if4.z_valid, if4.err_vec}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_decoder(vecs[i].stuck, 8'h00, 8'h00);
      run4(vecs[i].codes, {vecs[i].y, vecs[i].z, vecs[i].zv, vecs[i].err},
           vecs[i].spam, vecs[i].chg, vecs[i].name);
    end

    // reset in ISSUE of step 2 abandons the run
    set_decoder(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    if4.code_list = 12'b110_110_110_110;
    if4.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid y_vec", 32'(if4.y_vec[1:0]), 32'd3);
    check("mid state", 32'(if4.dbg_state), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid state", 32'(if4.dbg_state), 32'd0);
    check("rst_mid busy_done", {30'd0, if4.busy, if4.done}, 32'd0);
    check("rst_mid dec_abc", {29'd0, if4.dec_a, if4.dec_b, if4.dec_c}, 32'd0);
    check("rst_mid vectors", {16'd0, if4.y_vec, if4.z_vec, if4.z_valid, if4.err_vec}, 32'd0);
    run4(vecs[0].codes, {vecs[0].y, vecs[0].z, vecs[0].zv, vecs[0].err}, 0, 0, "post_rst");

    // single-step instance
    @(negedge clk);
    if1.code_list = 3'b110;
    if1.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    check("n1 issue dec", {29'd0, if1.dec_a, if1.dec_b, if1.dec_c}, 32'b110);
    check("n1 issue busy", 32'(if1.busy), 32'd1);
    @(negedge clk);
    check("n1 capture dec", {29'd0, if1.dec_a, if1.dec_b, if1.dec_c}, 32'b110);
    check("n1 capture done", 32'(if1.done), 32'd0);
    @(negedge clk);
    check("n1 done", {30'd0, if1.done, if1.busy}, 32'b10);
    check("n1 results", {28'd0, if1.y_vec, if1.z_vec, if1.z_valid, if1.err_vec}, 32'b1110);
    @(negedge clk);
    check("n1 done pulse", 32'(if1.done), 32'd0);

    // randomized runs with random decoder faults
    for (int r = 0; r < 16; r++) begin
      rc  = 12'($urandom);
      rs  = ($urandom_range(0, 3) == 0);
      rfy = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      rfz = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      set_decoder(rs, rfy, rfz);
      run4(rc, model4(rc, rs, rfy, rfz), 0, 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
